obsidian_hazard_controller: RTL and testbench
=============================================

Name: obsidian_hazard_controller

Overview:
- Pipeline sequencing controller for the Obsidian 5-stage datapath.
- Detects load-use hazards between ID/EX and IF/ID, and stalls PC and IF/ID while injecting a bubble into ID/EX.
- Sequences flushes of IF/ID, ID/EX and EX/MEM when a taken branch resolves from EX/MEM (Branch & Zero).
- Keeps saturating stall and flush event counters for debug.

Parameters:
- LOAD_STALL_CYCLES, 1: bubble cycles per load-use hazard; legal range 1..7.
- FLUSH_CYCLES, 1: flush cycles per taken branch; legal range 1..7.
- ZERO_REG, 31: register index that never creates a hazard (XZR).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- idex_memread  in  1  MemRead bit of the instruction in ID/EX.
- idex_rd  in  5  destination register of the ID/EX instruction.
- ifid_rn  in  5  Rn field of the IF/ID instruction.
- ifid_rm  in  5  Rm field of the IF/ID instruction.
- ifid_uses_rn  in  1  IF/ID instruction reads Rn.
- ifid_uses_rm  in  1  IF/ID instruction reads Rm (0 when ALUSrc selects the immediate).
- exmem_branch  in  1  Branch bit in EX/MEM.
- exmem_zero  in  1  Zero flag in EX/MEM.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  zero the control bits latched into ID/EX.
- flush_ifid  out  1  clear IF/ID to NOP.
- flush_idex  out  1  clear ID/EX control bits.
- flush_exmem  out  1  clear EX/MEM control bits [106:102].
- pc_src  out  1  select the branch target (EX/MEM[101:70]) for the PC.
- ctl_state  out  2  current state: 00 RUN, 01 STALL, 10 FLUSH.
- stall_count  out  16  load-use bubble cycles, saturating.
- flush_count  out  16  taken-branch events, saturating.

Behaviour:
- Definitions:
  - taken = exmem_branch & exmem_zero.
  - hazard = idex_memread & (idex_rd != ZERO_REG) & ((ifid_uses_rn & idex_rd == ifid_rn) | (ifid_uses_rm & idex_rd == ifid_rm)).
- Registered: state, 3-bit down-counter cnt, stall_count, flush_count. All other outputs are combinational from state, cnt and inputs (same-cycle effect).
- Reset (rst=1 at a clock edge): state=RUN, cnt=0, both event counters=0.
  - While rst is high: pc_write=0, ifid_write=0, idex_bubble=1, all flush_*=0, pc_src=0.
  - Reset mid-STALL or mid-FLUSH abandons the sequence immediately.
- Defaults, unless overridden below: pc_write=1, ifid_write=1, all other controls 0.
- RUN:
  - If taken: pc_src=1 and flush_ifid=flush_idex=flush_exmem=1. Next state is FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - Else if hazard: pc_write=0, ifid_write=0, idex_bubble=1. Next state is STALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
- STALL:
  - Drives pc_write=0, ifid_write=0, idex_bubble=1.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - A taken branch in STALL takes priority: branch-flush outputs as in RUN, the stall is abandoned, and the RUN transition rules for taken apply.
- FLUSH:
  - Drives flush_ifid=1, flush_idex=1, pc_src=0, pc_write=1. flush_exmem stays 0 (EX/MEM already holds a post-branch instruction only on the first cycle).
  - cnt decrements; when cnt==1, next state is RUN.
  - hazard is ignored in FLUSH; a new taken branch restarts FLUSH.
- Priority: rst > taken > hazard.
- Counters:
  - stall_count increments in every non-reset cycle with idex_bubble=1.
  - flush_count increments in every non-reset cycle with pc_src=1.
  - Both hold at 16'hFFFF.
- ctl_state always reflects the registered state.

Test Plan:
- Reset: hold rst 2 cycles -> pc_write=0, idex_bubble=1, ctl_state=00, both counters 0. Release -> pc_write=1, ifid_write=1, no flushes.
- Load-use (defaults): idex_memread=1, idex_rd=5, ifid_rn=5, ifid_uses_rn=1 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle back to normal; stall_count=1.
- No false hazard: idex_rd=31=ifid_rm with memread=1 -> no stall. idex_rd=7=ifid_rm but ifid_uses_rm=0 -> no stall.
- Multi-cycle stall with preemption: LOAD_STALL_CYCLES=3, hazard pulse -> 3 bubble cycles, stall_count=3, ctl_state 00,01,01,00. Repeat with taken asserted in the 2nd stall cycle -> that cycle pc_src=1 and all three flushes=1, then RUN; stall_count=2 for that run.
- Branch flush: FLUSH_CYCLES=2, exmem_branch=1, exmem_zero=1 together with a hazard -> cycle 1: pc_src=1, all flushes 1, no stall. Cycle 2: flush_ifid=flush_idex=1, pc_src=0, flush_exmem=0. Cycle 3: RUN; flush_count=1.
- Saturation and mid-sequence reset: force 65536 bubble cycles -> stall_count=16'hFFFF and stays there. Assert rst during FLUSH -> next cycle state=RUN and counters=0.

Source files
------------

// File: rtl/obsidian_hazard_controller.sv
// obsidian_hazard_controller
//   Pipeline sequencing controller for the Obsidian 5-stage datapath.
//   Stalls PC and IF/ID while bubbling ID/EX on load-use hazards, and
//   sequences IF/ID, ID/EX and EX/MEM flushes when a taken branch resolves
//   in EX/MEM. Keeps saturating debug counters of bubble cycles and taken
//   branches.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   idex_memread, idex_rd    load indicator and destination of the ID/EX instruction
//   ifid_rn/rm, ifid_uses_*  source registers of the IF/ID instruction and their use
//   exmem_branch, exmem_zero branch resolution inputs from EX/MEM
//   pc_write, ifid_write     load enables (0 = hold)
//   idex_bubble              zero control bits latched into ID/EX
//   flush_ifid/idex/exmem    clear the corresponding pipeline register
//   pc_src                   select branch target for the PC
//   ctl_state                00 RUN, 01 STALL, 10 FLUSH
//   stall_count, flush_count saturating event counters
module obsidian_hazard_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter logic [4:0]  ZERO_REG          = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rn,
  input  logic [4:0]  ifid_rm,
  input  logic        ifid_uses_rn,
  input  logic        ifid_uses_rm,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        pc_src,
  output logic [1:0]  ctl_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  // The first sequence cycle happens in RUN, so the counter is loaded
  // with the number of remaining cycles spent in STALL/FLUSH.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       taken;
  logic       hazard;

  assign taken  = exmem_branch & exmem_zero;
  assign hazard = idex_memread & (idex_rd != ZERO_REG) &
                  ((ifid_uses_rn & (idex_rd == ifid_rn)) |
                   (ifid_uses_rm & (idex_rd == ifid_rm)));

  assign ctl_state = state;

  // Control outputs: same-cycle function of state and inputs.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    pc_src      = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (taken) begin
      // A taken branch overrides any state, including an ongoing stall.
      pc_src      = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        FLUSH: begin
          // EX/MEM only holds a wrong-path instruction on the first cycle.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (idex_bubble && (stall_count != '1)) stall_count <= stall_count + 16'd1;
      if (pc_src && (flush_count != '1))      flush_count <= flush_count + 16'd1;

      if (taken) begin
        if (FLUSH_CYCLES > 1) begin
          state <= FLUSH;
          cnt   <= FLUSH_INIT;
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end else begin
        case (state)
          RUN: begin
            if (hazard && (LOAD_STALL_CYCLES > 1)) begin
              state <= STALL;
              cnt   <= STALL_INIT;
            end
          end
          STALL, FLUSH: begin
            if (cnt == 3'd1) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obsidian_hazard_controller.sv
module tb_obsidian_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       idex_memread;
  logic [4:0] idex_rd, ifid_rn, ifid_rm;
  logic       ifid_uses_rn, ifid_uses_rm, exmem_branch, exmem_zero;

  // Instance 0: default parameters. Instance 1: 3 stall cycles, 2 flush cycles.
  logic [1:0]  pc_write_v, ifid_write_v, idex_bubble_v, flush_ifid_v;
  logic [1:0]  flush_idex_v, flush_exmem_v, pc_src_v;
  logic [1:0]  st_v [2];
  logic [15:0] sc_v [2];
  logic [15:0] fc_v [2];

  obsidian_hazard_controller dut_a (
    .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rn(ifid_uses_rn),
    .ifid_uses_rm(ifid_uses_rm), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .pc_write(pc_write_v[0]), .ifid_write(ifid_write_v[0]), .idex_bubble(idex_bubble_v[0]),
    .flush_ifid(flush_ifid_v[0]), .flush_idex(flush_idex_v[0]), .flush_exmem(flush_exmem_v[0]),
    .pc_src(pc_src_v[0]), .ctl_state(st_v[0]), .stall_count(sc_v[0]), .flush_count(fc_v[0])
  );

  obsidian_hazard_controller #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rn(ifid_uses_rn),
    .ifid_uses_rm(ifid_uses_rm), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .pc_write(pc_write_v[1]), .ifid_write(ifid_write_v[1]), .idex_bubble(idex_bubble_v[1]),
    .flush_ifid(flush_ifid_v[1]), .flush_idex(flush_idex_v[1]), .flush_exmem(flush_exmem_v[1]),
    .pc_src(pc_src_v[1]), .ctl_state(st_v[1]), .stall_count(sc_v[1]), .flush_count(fc_v[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model: number of bubble / flush cycles still owed after the
  // current one, plus plain integer event counts.
  int          p_stall [2] = '{1, 3};
  int          p_flush [2] = '{1, 2};
  int          m_stall_rem [2];
  int          m_flush_rem [2];
  int          m_sc [2];
  int          m_fc [2];
  logic [8:0]  m_exp [2];   // {pw, iw, bubble, f_ifid, f_idex, f_exmem, pc_src, state[1:0]}

  function automatic logic model_hazard();
    return idex_memread && (idex_rd != 5'd31) &&
           ((ifid_uses_rn && idex_rd == ifid_rn) || (ifid_uses_rm && idex_rd == ifid_rm));
  endfunction

  function automatic logic [8:0] model_out(input int i);
    logic [6:0] c;
    logic [1:0] st;
    st = (m_stall_rem[i] > 0) ? 2'b01 : (m_flush_rem[i] > 0) ? 2'b10 : 2'b00;
    if (rst)                                   c = 7'b0010000;
    else if (exmem_branch && exmem_zero)       c = 7'b1101111;
    else if (m_flush_rem[i] > 0)               c = 7'b1101100;
    else if (m_stall_rem[i] > 0 || model_hazard()) c = 7'b0010000;
    else                                       c = 7'b1100000;
    return {c, st};
  endfunction

  function automatic logic [8:0] obs_ctl(input int i);
    return {pc_write_v[i], ifid_write_v[i], idex_bubble_v[i], flush_ifid_v[i],
            flush_idex_v[i], flush_exmem_v[i], pc_src_v[i], st_v[i]};
  endfunction

  task automatic model_commit(input int i);
    if (rst) begin
      m_stall_rem[i] = 0; m_flush_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else begin
      if (m_exp[i][6] && m_sc[i] < 65535) m_sc[i]++;
      if (m_exp[i][2] && m_fc[i] < 65535) m_fc[i]++;
      if (exmem_branch && exmem_zero) begin
        m_stall_rem[i] = 0;
        m_flush_rem[i] = p_flush[i] - 1;
      end else if (m_flush_rem[i] > 0) m_flush_rem[i]--;
      else if (m_stall_rem[i] > 0)     m_stall_rem[i]--;
      else if (model_hazard())         m_stall_rem[i] = p_stall[i] - 1;
    end
  endtask

  task automatic settle();
    #1;
    for (int i = 0; i < 2; i++) m_exp[i] = model_out(i);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_commit(i);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; idex_memread = 1'b0; idex_rd = 5'd0; ifid_rn = 5'd0; ifid_rm = 5'd0;
    ifid_uses_rn = 1'b0; ifid_uses_rm = 1'b0; exmem_branch = 1'b0; exmem_zero = 1'b0;
  endtask

  // op: 0 idle, 1 load-use hazard, 2 taken branch, 3 taken branch + hazard
  task automatic apply_op(input int op);
    idle();
    if (op == 1 || op == 3) begin
      idex_memread = 1'b1; idex_rd = 5'd5; ifid_rn = 5'd5; ifid_uses_rn = 1'b1;
    end
    if (op >= 2) begin
      exmem_branch = 1'b1; exmem_zero = 1'b1;
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; settle(); advance(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_ctl(i) !== m_exp[i]) begin
          errors++; $display("FAIL reset_ctl dut%0d got %b exp %b", i, obs_ctl(i), m_exp[i]);
        end
      end
      advance();
    end
    idle(); settle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({sc_v[i], fc_v[i]} !== 32'd0) begin
        errors++; $display("FAIL reset_counts dut%0d got %h/%h exp 0/0", i, sc_v[i], fc_v[i]);
      end
      checks++;
      if (obs_ctl(i) !== 9'b1100000_00) begin
        errors++; $display("FAIL reset_release dut%0d got %b exp %b", i, obs_ctl(i), 9'b1100000_00);
      end
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [8:0] exp_a [3] = '{9'b0010000_00, 9'b1100000_00, 9'b1100000_00};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      apply_op(c == 0 ? 1 : 0); settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_ctl(i) !== m_exp[i] || sc_v[i] !== 16'(m_sc[i])) begin
          errors++; $display("FAIL load_use c%0d dut%0d got %b/%0d exp %b/%0d", c, i, obs_ctl(i), sc_v[i], m_exp[i], m_sc[i]);
        end
      end
      if (c < 3) begin
        checks++;
        if (obs_ctl(0) !== exp_a[c]) begin
          errors++; $display("FAIL load_use_direct c%0d got %b exp %b", c, obs_ctl(0), exp_a[c]);
        end
      end
      advance();
    end
    checks++;
    if (sc_v[0] !== 16'd1) begin
      errors++; $display("FAIL load_use_count got %0d exp 1", sc_v[0]);
    end
  endtask

  task automatic test_no_false_hazard();
    for (int c = 0; c < 2; c++) begin
      idle(); idex_memread = 1'b1;
      if (c == 0) begin idex_rd = 5'd31; ifid_rm = 5'd31; ifid_uses_rm = 1'b1; end
      else        begin idex_rd = 5'd7;  ifid_rm = 5'd7;  ifid_uses_rm = 1'b0; end
      settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_ctl(i) !== 9'b1100000_00 || obs_ctl(i) !== m_exp[i]) begin
          errors++; $display("FAIL no_false_hazard c%0d dut%0d got %b exp %b", c, i, obs_ctl(i), 9'b1100000_00);
        end
      end
      advance();
    end
  endtask

  task automatic test_multi_stall();
    int         ops [2][5] = '{'{1, 0, 0, 0, 0}, '{1, 0, 2, 0, 0}};
    logic [8:0] exp_b [2][5] = '{
      '{9'b0010000_00, 9'b0010000_01, 9'b0010000_01, 9'b1100000_00, 9'b1100000_00},
      '{9'b0010000_00, 9'b0010000_01, 9'b1101111_01, 9'b1101100_10, 9'b1100000_00}};
    logic [15:0] exp_sc [2] = '{16'd3, 16'd2};
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int c = 0; c < 5; c++) begin
        apply_op(ops[r][c]); settle();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs_ctl(i) !== m_exp[i]) begin
            errors++; $display("FAIL multi_stall r%0d c%0d dut%0d got %b exp %b", r, c, i, obs_ctl(i), m_exp[i]);
          end
        end
        checks++;
        if (obs_ctl(1) !== exp_b[r][c]) begin
          errors++; $display("FAIL multi_stall_direct r%0d c%0d got %b exp %b", r, c, obs_ctl(1), exp_b[r][c]);
        end
        advance();
      end
      checks++;
      if (sc_v[1] !== exp_sc[r]) begin
        errors++; $display("FAIL multi_stall_count r%0d got %0d exp %0d", r, sc_v[1], exp_sc[r]);
      end
    end
  endtask

  task automatic test_branch_flush();
    logic [8:0] exp_b [3] = '{9'b1101111_00, 9'b1101100_10, 9'b1100000_00};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply_op(c == 0 ? 3 : 0); settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_ctl(i) !== m_exp[i]) begin
          errors++; $display("FAIL branch_flush c%0d dut%0d got %b exp %b", c, i, obs_ctl(i), m_exp[i]);
        end
      end
      checks++;
      if (obs_ctl(1) !== exp_b[c]) begin
        errors++; $display("FAIL branch_flush_direct c%0d got %b exp %b", c, obs_ctl(1), exp_b[c]);
      end
      advance();
    end
    checks++;
    if (fc_v[1] !== 16'd1 || fc_v[0] !== 16'd1 || sc_v[1] !== 16'd0) begin
      errors++; $display("FAIL branch_flush_count got %0d/%0d/%0d exp 1/1/0", fc_v[0], fc_v[1], sc_v[1]);
    end
  endtask

  task automatic test_random();
    logic [4:0] regs [4] = '{5'd5, 5'd7, 5'd31, 5'd0};
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 29) == 0);
      idex_memread = 1'($urandom_range(0, 1));
      idex_rd      = regs[$urandom_range(0, 3)];
      ifid_rn      = ($urandom_range(0, 1) == 1) ? idex_rd : 5'($urandom);
      ifid_rm      = ($urandom_range(0, 1) == 1) ? idex_rd : 5'($urandom);
      ifid_uses_rn = 1'($urandom_range(0, 1));
      ifid_uses_rm = 1'($urandom_range(0, 1));
      exmem_branch = 1'($urandom_range(0, 1));
      exmem_zero   = ($urandom_range(0, 3) == 0);
      settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_ctl(i) !== m_exp[i] || sc_v[i] !== 16'(m_sc[i]) || fc_v[i] !== 16'(m_fc[i])) begin
          errors++;
          $display("FAIL random c%0d dut%0d got %b/%0d/%0d exp %b/%0d/%0d", c, i,
                   obs_ctl(i), sc_v[i], fc_v[i], m_exp[i], m_sc[i], m_fc[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    apply_op(1);
    for (int c = 0; c < 65540; c++) begin
      settle(); advance();
    end
    for (int k = 0; k < 2; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (sc_v[i] !== 16'hFFFF || m_sc[i] != 65535) begin
          errors++; $display("FAIL saturation k%0d dut%0d got %h exp ffff", k, i, sc_v[i]);
        end
      end
      for (int c = 0; c < 3; c++) begin settle(); advance(); end
    end
    apply_op(2); settle(); advance();
    idle(); settle();
    checks++;
    if (st_v[1] !== 2'b10) begin
      errors++; $display("FAIL enter_flush got %b exp 10", st_v[1]);
    end
    rst = 1'b1; settle(); advance();
    idle(); settle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (st_v[i] !== 2'b00 || sc_v[i] !== 16'd0 || fc_v[i] !== 16'd0 || obs_ctl(i) !== m_exp[i]) begin
        errors++; $display("FAIL mid_flush_reset dut%0d got %b/%0d/%0d exp 00/0/0", i, st_v[i], sc_v[i], fc_v[i]);
      end
    end
    advance();
  endtask

  initial begin
    idle(); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_stall_rem[i] = 0; m_flush_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
    @(negedge clk);
    settle(); advance();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_multi_stall();
    test_branch_flush();
    test_random();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
